// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard front end: oversampled clock filter, frame checker, E0/F0 prefix folding
// and a show-ahead event FIFO with interrupt and error reporting, all in the CLOCK_50 domain.
`timescale 1ns/1ps
module ps2_scan_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int REPORT_BREAK   = 1
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  input  logic                          irq_ack,
  input  logic                          err_clr,
  output logic [15:0]                   rdata,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          irq,
  output logic                          overflow,
  output logic [7:0]                    err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_s, data_s;
  logic [FW-1:0] filt_cnt;
  logic          filt_clk, filt_prev, strobe;

  state_t        state;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] timer;
  logic          byte_valid, err_evt;

  logic          ext_pend, brk_pend;
  logic          is_e0, is_f0, push, pop, full, do_push;
  logic [9:0]    entry;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // The filtered clock only flips after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      filt_cnt  <= '0;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign strobe = filt_prev & ~filt_clk;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      timer      <= '0;
      byte_valid <= 1'b0;
      err_evt    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      err_evt    <= 1'b0;
      if (strobe) begin
        timer <= '0;
        case (state)
          IDLE: begin
            if (!data_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              err_evt <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= {data_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_s;
            state   <= STOP;
          end
          default: begin
            if (data_s && ((^shreg) ^ par_bit)) byte_valid <= 1'b1;
            else                                err_evt    <= 1'b1;
            state <= IDLE;
          end
        endcase
      end else if (state != IDLE) begin
        // Abandon a stalled frame so the next one starts cleanly.
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state   <= IDLE;
          err_evt <= 1'b1;
          timer   <= '0;
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

  assign is_e0 = (shreg == 8'hE0);
  assign is_f0 = (shreg == 8'hF0);
  assign entry = {brk_pend, ext_pend, shreg};
  assign push  = byte_valid && !is_e0 && !is_f0 && ((REPORT_BREAK != 0) || !brk_pend);

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (err_evt) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_valid) begin
      if (is_e0) begin
        ext_pend <= 1'b1;
      end else if (is_f0) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = rd_en && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || pop);
  assign rdata   = empty ? 16'h0000 : {6'b0, mem[rd_ptr]};

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      irq      <= 1'b0;
      overflow <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (do_push)      irq <= 1'b1;
      else if (irq_ack) irq <= 1'b0;

      if (push && !do_push) overflow <= 1'b1;
      else if (err_clr)     overflow <= 1'b0;

      if (err_evt)      err_cnt <= err_clr ? 8'd1 : ((err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1);
      else if (err_clr) err_cnt <= '0;
    end
  end

endmodule
